// File: rtl/mem_loader.sv
// Push-button data-memory loader: debounces btn_in, writes sw_data to WORDS slots, then raises over.
// Optional MEM_LOADER_SYNC_EN adds a two-flop synchronizer in front of the debouncer.
module mem_loader #(
  parameter int WORDS           = 10,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        btn_in,
  input  logic [15:0] sw_data,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [9:0]  led_onehot,
  output logic        over,
  output logic [1:0]  dbg_state
);

  localparam int             CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     LAST_IDX = 4'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic btn_s;

`ifdef MEM_LOADER_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = btn_in;
`endif

  state_t           state_q, state_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [15:0]      cap_q, cap_d;
  logic             wr_en_q, wr_en_d;
  logic [3:0]       wr_addr_q, wr_addr_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic [3:0]       wr_count_q, wr_count_d;
  logic             over_q, over_d;
  logic             press_rise;

  // Debouncer: cnt_q counts consecutive samples that disagree with db_q.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (btn_s != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = btn_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_rise = (state_q == ST_LOAD) && !db_q && db_d;

  // ARM waits for a released button so a press held through reset never writes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM:  if (!db_q && !btn_s) state_d = ST_LOAD;
      ST_LOAD: if (pend_q && (wr_count_q == LAST_IDX)) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_ARM;
    endcase
  end

  // Write port: wr_en is a one-cycle strobe with no backpressure; wr_addr/wr_data
  // are valid while wr_en is high and hold their last values otherwise.
  always_comb begin
    pend_d     = press_rise;
    cap_d      = press_rise ? sw_data : cap_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;
    over_d     = (state_q == ST_DONE);
    if (pend_q) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_count_q;
      wr_data_d = cap_q;
      if (wr_count_q != 4'hF) wr_count_d = wr_count_q + 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q    <= ST_ARM;
      db_q       <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      cap_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      cap_q      <= cap_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
      over_q     <= over_d;
    end
  end

  always_comb begin
    led_onehot = 10'h200 >> wr_count_q;
    if (state_q == ST_DONE) led_onehot = '0;
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign over      = over_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader with DEBOUNCE_CYCLES=4, WORDS=10; writes are scored against an expected queue.
module tb_mem_loader;

  localparam int D = 4;
`ifdef MEM_LOADER_SYNC_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D;
`endif

  logic        Clk;
  logic        Clr;
  logic        btn_in;
  logic [15:0] sw_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [9:0]  led_onehot;
  logic        over;
  logic [1:0]  dbg_state;

  mem_loader #(.WORDS(10), .DEBOUNCE_CYCLES(D)) dut (
    .Clk(Clk), .Clr(Clr), .btn_in(btn_in), .sw_data(sw_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .led_onehot(led_onehot), .over(over), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [19:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_wr = 0;
  int last_wr_cyc = -1;
  int over_rise_cyc = -1;
  logic over_prev = 1'b0;

  // One clock; outputs sampled 1 time unit after the edge and writes scored.
  task automatic step();
    logic [19:0] e;
    @(posedge Clk);
    cyc++;
    #1;
    if (wr_en === 1'b1) begin
      n_wr++;
      last_wr_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr, wr_data, e[19:16], e[15:0]);
        end
      end
    end
    if (over === 1'b1 && over_prev === 1'b0) over_rise_cyc = cyc;
    over_prev = over;
  endtask

  // Driver tasks
  task automatic do_reset();
    Clr = 1'b0;
    repeat (2) step();
    Clr = 1'b1;
    repeat (2) step();
  endtask

  task automatic press(input logic [15:0] d, input int hold);
    sw_data = d;
    btn_in  = 1'b1;
    repeat (hold) step();
    btn_in = 1'b0;
    repeat (D + 2) step();
  endtask

  task automatic test_reset();
    Clr = 1'b0;
    btn_in = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({wr_en, wr_addr, wr_data, over, led_onehot, dbg_state} !== {1'b0, 4'd0, 16'd0, 1'b0, 10'h200, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h over=%b led=%b st=%0d, expected 0 0 0000 0 1000000000 0",
               wr_en, wr_addr, wr_data, over, led_onehot, dbg_state);
    end
    Clr = 1'b1;
    repeat (4) step();
    n_checks++;
    if (dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_to_load: got state=%0d, expected 1", dbg_state);
    end
  endtask

  task automatic test_single();
    int k;
    int wr0;
    wr0 = n_wr;
    exp_q.push_back({4'd0, 16'h00A5});
    k = cyc + 1;
    press(16'h00A5, 10);
    n_checks++;
    if (n_wr - wr0 !== 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d writes, expected 1", n_wr - wr0);
    end
    n_checks++;
    if (last_wr_cyc !== k + LAT) begin
      n_fail++;
      $display("FAIL single_latency: got cycle %0d, expected %0d", last_wr_cyc, k + LAT);
    end
    n_checks++;
    if (led_onehot !== 10'b0100000000) begin
      n_fail++;
      $display("FAIL single_led: got %b, expected 0100000000", led_onehot);
    end
    n_checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b0, 4'd0, 16'h00A5}) begin
      n_fail++;
      $display("FAIL single_hold: got en=%b addr=%0d data=%h, expected 0 0 00a5", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_bounce();
    int wr0;
    wr0 = n_wr;
    sw_data = 16'hBEEF;
    for (int i = 0; i < 20; i++) begin
      btn_in = i[0] ? 1'b0 : 1'b1;
      step();
    end
    btn_in = 1'b0;
    repeat (D + 2) step();
    n_checks++;
    if (n_wr !== wr0) begin
      n_fail++;
      $display("FAIL bounce_writes: got %0d writes, expected 0", n_wr - wr0);
    end
    n_checks++;
    if (led_onehot !== 10'b0100000000) begin
      n_fail++;
      $display("FAIL bounce_led: got %b, expected 0100000000", led_onehot);
    end
  endtask

  task automatic test_fill();
    int wr0;
    do_reset();
    wr0 = n_wr;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({4'(i), 16'(9 - i)});
      press(16'(9 - i), $urandom_range(D + 1, D + 4));
    end
    n_checks++;
    if (n_wr - wr0 !== 10) begin
      n_fail++;
      $display("FAIL fill_count: got %0d writes, expected 10", n_wr - wr0);
    end
    n_checks++;
    if (over_rise_cyc !== last_wr_cyc + 1) begin
      n_fail++;
      $display("FAIL fill_over_timing: got over rise %0d, expected %0d", over_rise_cyc, last_wr_cyc + 1);
    end
    n_checks++;
    if ({over, led_onehot} !== {1'b1, 10'd0}) begin
      n_fail++;
      $display("FAIL fill_done: got over=%b led=%b, expected 1 0000000000", over, led_onehot);
    end
    wr0 = n_wr;
    press(16'h1234, 8);
    n_checks++;
    if (n_wr !== wr0 || over !== 1'b1) begin
      n_fail++;
      $display("FAIL extra_press: got %0d writes over=%b, expected 0 writes over=1", n_wr - wr0, over);
    end
  endtask

  task automatic test_reset_mid();
    int wr0;
    do_reset();
    exp_q.push_back({4'd0, 16'h0011});
    press(16'h0011, 6);
    exp_q.push_back({4'd1, 16'h0022});
    press(16'h0022, 6);
    exp_q.push_back({4'd2, 16'h0033});
    sw_data = 16'h0033;
    btn_in  = 1'b1;
    repeat (6) step();
    Clr = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({wr_en, wr_addr, wr_data, led_onehot} !== {1'b0, 4'd0, 16'd0, 10'h200}) begin
      n_fail++;
      $display("FAIL midreset_clear: got en=%b addr=%0d data=%h led=%b, expected 0 0 0000 1000000000",
               wr_en, wr_addr, wr_data, led_onehot);
    end
    Clr = 1'b1;
    wr0 = n_wr;
    repeat (12) step();
    n_checks++;
    if (n_wr !== wr0) begin
      n_fail++;
      $display("FAIL held_through_reset: got %0d writes, expected 0", n_wr - wr0);
    end
    btn_in = 1'b0;
    repeat (8) step();
    exp_q.push_back({4'd0, 16'h0044});
    press(16'h0044, 6);
    n_checks++;
    if (n_wr - wr0 !== 1 || led_onehot !== 10'b0100000000) begin
      n_fail++;
      $display("FAIL repress_after_reset: got %0d writes led=%b, expected 1 0100000000", n_wr - wr0, led_onehot);
    end
  endtask

  initial begin
    Clr = 1'b0;
    btn_in = 1'b0;
    sw_data = 16'h0000;
    test_reset();
    test_single();
    test_bounce();
    test_fill();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter WORDS, default 10: number of data words loaded before the sort phase starts (range 1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive equal samples required to change the debounced button level (minimum 2).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Clr  input  1  reset, synchronous, active-low.
REQ-005 btn_in  input  1  raw write push-button, active-high, may bounce.
REQ-006 sw_data  input  16  switch value to be written.
REQ-007 wr_en  output  1  one-cycle data-memory write strobe.
REQ-008 wr_addr  output  4  data-memory write address.
REQ-009 wr_data  output  16  data-memory write data.
REQ-010 led_onehot  output  10  slot indicator; bit (9-wr_count) high = next slot to fill.
REQ-011 over  output  1  input phase complete; starts CPU sort phase.

Function
REQ-012 Debouncer: the debounced level db shall take the value of the sampled button only after DEBOUNCE_CYCLES consecutive identical samples; any differing sample restarts the count.
REQ-013 FSM states ARM, LOAD, DONE; ARM -> LOAD when db==0; LOAD -> DONE on the accepted write with wr_count==WORDS-1; DONE is held until reset.
REQ-014 Only a 0->1 transition of db while in LOAD is an accepted press; transitions in ARM or DONE are ignored.
REQ-015 On an accepted press, sw_data shall be captured at the edge where db rises, and wr_en shall be high for exactly the following cycle with wr_addr=wr_count and wr_data=captured value.
REQ-016 wr_count (4-bit) shall increment by 1 in the same cycle wr_en is high; it shall never wrap, as LOAD exits at WORDS.
REQ-017 Latency (macro off): btn_in first sampled high at edge k and stable -> db high after edge k+DEBOUNCE_CYCLES-1 -> wr_en high during the cycle after edge k+DEBOUNCE_CYCLES.
REQ-018 A held button shall produce exactly one write; a new write requires db to return to 0 first.
REQ-019 over shall rise in the cycle after the final wr_en and remain 1; wr_en shall be 0 in DONE regardless of btn_in.
REQ-020 led_onehot: ARM/LOAD show 10'b1000000000 >> wr_count; DONE shows 10'b0000000000.
REQ-021 wr_data and wr_addr shall hold their last values when wr_en is 0.

Reset
REQ-022 Clr==0 at a rising edge: state=ARM, db=0, debounce counter=0, wr_count=0, wr_en=0, wr_addr=0, wr_data=0, over=0, led_onehot=10'b1000000000.
REQ-023 Reset mid-operation shall discard any pending capture; previously written memory words are not cleared by this block.
REQ-024 A button held through reset release shall not cause a write until it is released (db==0) and pressed again.

Configuration
REQ-025 Macro MEM_LOADER_SYNC_EN defined: btn_in shall pass through a two-flop synchronizer (reset to 0) before the debouncer, adding exactly 2 cycles to REQ-017 latency.
REQ-026 MEM_LOADER_SYNC_EN undefined: btn_in feeds the debouncer directly with the REQ-017 latency; all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, WORDS=10, macro off unless stated)
REQ-027 Clr low 2 cycles, btn_in=0 -> all outputs at REQ-022 values; state reaches LOAD 4 cycles after release.
REQ-028 sw_data=16'h00A5, btn_in high 10 cycles from edge k -> single wr_en at cycle k+4, wr_addr=0, wr_data=16'h00A5, led_onehot=10'b0100000000.
REQ-029 btn_in toggling every cycle for 20 cycles, then low -> no wr_en and wr_count unchanged.
REQ-030 Ten clean presses with sw_data=9..0 -> writes to addr 0..9 in order, over=1 one cycle after 10th write, led_onehot=0; an 11th press produces no wr_en.
REQ-031 Clr asserted after the 3rd write with btn_in held high -> wr_count=0; no write until btn_in released ≥4 cycles and pressed again, which then writes addr 0.
REQ-032 MEM_LOADER_SYNC_EN defined, repeat REQ-028 -> wr_en at cycle k+6, same address and data.
